// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared mode encodings and reset pattern for the pixel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        ROT_L     = 2'b01,
        ROT_R     = 2'b10,
        SHIFT_OUT = 2'b11
    } mode_e;

    localparam logic [23:0] c_default_reg = 24'h0F0F0F;

endpackage : pixel_pkg
`default_nettype wire

// File: rtl/pixel_load_expand.sv
`default_nettype none
// ============================================================================
// Module      : pixel_load_expand
// Description : Widens packed IN_W-bit channel values to CH_W-bit channels,
//               left-aligned with zero padding in the LSBs.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_load_expand #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 8,
    parameter int IN_W   = 4
) (
    input  logic [NUM_CH*IN_W-1:0] load_data,
    output logic [NUM_CH*CH_W-1:0] expanded
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        if (IN_W == CH_W) begin : g_full
            assign expanded[k*CH_W +: CH_W] = load_data[k*IN_W +: IN_W];
        end else begin : g_pad
            assign expanded[k*CH_W +: CH_W] =
                {load_data[k*IN_W +: IN_W], {(CH_W-IN_W){1'b0}}};
        end
    end

endmodule : pixel_load_expand
`default_nettype wire

// File: rtl/pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pixel_shifter
// Description : Loadable pixel register that rotates or shifts one bit per
//               step and flags completion of each W-step frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_shifter
    import pixel_pkg::*;
#(
    parameter int                       CH_W        = 8,
    parameter int                       NUM_CH      = 3,
    parameter int                       IN_W        = 4,
    parameter logic [NUM_CH*CH_W-1:0]   DEFAULT_REG = (NUM_CH*CH_W)'(c_default_reg)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic [NUM_CH*IN_W-1:0]      load_data,
    input  logic [1:0]                  mode,
    input  logic                        step,
    output logic                        current_bit,
    output logic [NUM_CH*CH_W-1:0]      reg_out,
    output logic [$clog2(NUM_CH*CH_W)-1:0] bit_index,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int             W      = NUM_CH * CH_W;
    localparam int             IDX_W  = $clog2(W);
    localparam logic [IDX_W-1:0] c_last = IDX_W'(W - 1);

    logic [W-1:0]     r_pix;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    logic             r_busy;

    logic [W-1:0]     w_expanded;
    logic [W-1:0]     w_shifted;
    mode_e            w_mode;
    logic             w_advance;

    assign w_mode    = mode_e'(mode);
    assign w_advance = step && (w_mode != HOLD);

    pixel_load_expand #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .IN_W   (IN_W)
    ) u_load_expand (
        .load_data (load_data),
        .expanded  (w_expanded)
    );

    always_comb begin
        w_shifted = r_pix;
        case (w_mode)
            ROT_L:     w_shifted = {r_pix[W-2:0], r_pix[W-1]};
            ROT_R:     w_shifted = {r_pix[0], r_pix[W-1:1]};
            SHIFT_OUT: w_shifted = {r_pix[W-2:0], 1'b0};
            default:   w_shifted = r_pix;
        endcase
    end

    // Load takes priority over step; frame_done is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix  <= DEFAULT_REG;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_pix  <= w_expanded;
                r_idx  <= '0;
                r_busy <= 1'b1;
            end else if (w_advance) begin
                r_pix <= w_shifted;
                if (r_idx == c_last) begin
                    r_idx  <= '0;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign current_bit = r_pix[W-1];
    assign reg_out     = r_pix;
    assign bit_index   = r_idx;
    assign frame_done  = r_done;
    assign busy        = r_busy;

endmodule : pixel_shifter
`default_nettype wire
